// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC cores: arctangent table, gain
// compensation factor, angle offsets and the vectoring FSM state encoding.
package cordic_pkg;

  // atan(2^-i) in Q2.30, i = 0..15
  localparam logic [31:0] ATAN_TABLE [0:15] = '{
    32'h3243F6A9, 32'h1DAC6705, 32'h0FADBAFD, 32'h07F56EA7,
    32'h03FEAB77, 32'h01FFD55C, 32'h00FFFAAB, 32'h007FFF55,
    32'h003FFFEB, 32'h001FFFFD, 32'h00100000, 32'h00080000,
    32'h00040000, 32'h00020000, 32'h00010000, 32'h00008000
  };

  localparam logic signed [31:0] K_GAIN           = 32'sh26DD3B6A;
  localparam logic signed [31:0] PI_HALF_Q329     = 32'sh3243F6A9;
  localparam logic signed [31:0] NEG_PI_HALF_Q329 = 32'shCDBC0957;
  localparam logic signed [31:0] PI_Q329          = 32'sh6487ED51;

  typedef enum logic [1:0] {IDLE, ITER, SCALE} state_t;

endpackage

// File: rtl/cordic_atan_rom.sv
// Arctangent lookup, indexed by iteration number; shared with the rotation core.
module cordic_atan_rom
  import cordic_pkg::*;
(
  input  logic [3:0]  i_idx,
  output logic [31:0] o_atan
);

  assign o_atan = ATAN_TABLE[i_idx];

endmodule

// File: rtl/cordic_vector.sv
// Iterative 16-step vectoring-mode CORDIC: returns atan2(y, x) in Q3.29 and the
// gain-compensated magnitude in Q2.30, 17 cycles after start is accepted.
module cordic_vector
  import cordic_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [31:0] x_in,
  input  logic signed [31:0] y_in,
  output logic        [31:0] angle_out,
  output logic        [31:0] mag_out,
  output logic               busy,
  output logic               done
);

  state_t             r_state, w_next;
  logic        [3:0]  r_i;
  logic signed [31:0] r_x, r_y, r_z, r_offset;
  logic               r_zero;

  logic        [31:0] w_atan;
  logic signed [31:0] w_xsh, w_ysh;
  logic signed [31:0] w_xpre, w_ypre, w_offpre;
  logic signed [63:0] w_prod;
  logic signed [31:0] w_mag, w_angle;

  cordic_atan_rom u_rom (
    .i_idx  (r_i),
    .o_atan (w_atan)
  );

  // Left-half-plane inputs are rotated by +/-90 degrees so the iterations
  // only ever have to cover the right half plane.
  always_comb begin
    w_xpre   = x_in;
    w_ypre   = y_in;
    w_offpre = '0;
    if (x_in[31]) begin
      if (!y_in[31]) begin
        w_xpre   = y_in;
        w_ypre   = -x_in;
        w_offpre = PI_HALF_Q329;
      end else begin
        w_xpre   = -y_in;
        w_ypre   = x_in;
        w_offpre = NEG_PI_HALF_Q329;
      end
    end
  end

  assign w_xsh   = r_x >>> r_i;
  assign w_ysh   = r_y >>> r_i;
  assign w_prod  = {{32{r_x[31]}}, r_x} * {{32{K_GAIN[31]}}, K_GAIN};
  assign w_mag   = 32'(w_prod >>> 30);
  assign w_angle = (r_z >>> 1) + r_offset;
  assign busy    = (r_state != IDLE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = ITER;
      ITER:    if (r_i == 4'd15) w_next = SCALE;
      SCALE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_i       <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_z       <= '0;
      r_offset  <= '0;
      r_zero    <= 1'b0;
      angle_out <= '0;
      mag_out   <= '0;
      done      <= 1'b0;
    end else begin
      r_state <= w_next;
      done    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_x      <= w_xpre;
            r_y      <= w_ypre;
            r_z      <= '0;
            r_offset <= w_offpre;
            r_i      <= '0;
            r_zero   <= (x_in == 32'sd0) && (y_in == 32'sd0);
          end
        end
        ITER: begin
          // Steer y toward zero; the sign of y picks the rotation direction.
          if (!r_y[31]) begin
            r_x <= r_x + w_ysh;
            r_y <= r_y - w_xsh;
            r_z <= r_z + w_atan;
          end else begin
            r_x <= r_x - w_ysh;
            r_y <= r_y + w_xsh;
            r_z <= r_z - w_atan;
          end
          r_i <= r_i + 4'd1;
        end
        SCALE: begin
          angle_out <= r_zero ? 32'd0 : w_angle;
          mag_out   <= r_zero ? 32'd0 : w_mag;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vector.sv
// Self-checking bench for cordic_vector: fixed vectors, random vectors against
// a real-arithmetic atan2/sqrt model, and handshake/reset corner sequences.
module tb_cordic_vector;

  logic               clk = 1'b0;
  logic               reset, start;
  logic signed [31:0] x_in, y_in;
  logic        [31:0] angle_out, mag_out;
  logic               busy, done;

  int nChecks = 0;
  int nErrors = 0;

  localparam real PI_R    = 3.14159265358979323846;
  localparam real ANG_TOL = 32768.0 / 536870912.0;
  localparam real MAG_TOL = 32768.0 / 1073741824.0;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] expAngle;
    logic [31:0] expMag;
    int          tol;
  } vec_t;

  vec_t vecs [6];

  cordic_vector dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .angle_out (angle_out),
    .mag_out   (mag_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] exp, input int tol);
    int diff;
    diff = int'(got - exp);
    if (diff < 0) diff = -diff;
    nChecks++;
    if (diff > tol) begin
      nErrors++;
      $display("[TB] FAIL %s: got %h, expected %h (tol %0d)", name, got, exp, tol);
    end
  endtask

  // Reference: atan2 and Euclidean norm of the input vector in real arithmetic.
  task automatic checkModel(input string name, input logic [31:0] x, input logic [31:0] y);
    real xr, yr, expA, expM, gotA, gotM, dA;
    if (x == 32'd0 && y == 32'd0) begin
      checkOutput({name, " angle"}, angle_out, 32'd0, 0);
      checkOutput({name, " mag"}, mag_out, 32'd0, 0);
      return;
    end
    xr   = real'($signed(x)) / 1073741824.0;
    yr   = real'($signed(y)) / 1073741824.0;
    expA = $atan2(yr, xr);
    expM = $sqrt(xr * xr + yr * yr);
    gotA = real'($signed(angle_out)) / 536870912.0;
    gotM = real'($signed(mag_out)) / 1073741824.0;
    dA   = gotA - expA;
    if (dA > PI_R)  dA = dA - 2.0 * PI_R;
    if (dA < -PI_R) dA = dA + 2.0 * PI_R;
    nChecks++;
    if (dA > ANG_TOL || dA < -ANG_TOL) begin
      nErrors++;
      $display("[TB] FAIL %s angle: x=%h y=%h got %f, expected %f rad", name, x, y, gotA, expA);
    end
    nChecks++;
    if (gotM - expM > MAG_TOL || expM - gotM > MAG_TOL) begin
      nErrors++;
      $display("[TB] FAIL %s mag: x=%h y=%h got %f, expected %f", name, x, y, gotM, expM);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y);
    x_in  = x;
    y_in  = y;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic runModelOp(input string name, input logic [31:0] x, input logic [31:0] y);
    int lat;
    applyStimulus(x, y);
    waitDone(lat);
    checkOutput({name, " latency"}, lat, 32'd17, 0);
    if (lat > 0) checkModel(name, x, y);
  endtask

  function automatic logic [31:0] randComp();
    int v;
    v = int'($urandom_range(32'h60000000, 0)) - 32'sh30000000;
    return v;
  endfunction

  function automatic int absInt(input logic [31:0] v);
    int s;
    s = int'(v);
    return (s < 0) ? -s : s;
  endfunction

  initial begin
    int lat, doneCount, seen;
    logic [31:0] rx, ry;

    vecs[0] = '{32'h20000000, 32'h00000000, 32'h00000000, 32'h20000000, 32'h8000};
    vecs[1] = '{32'h20000000, 32'h20000000, 32'h1921FB54, 32'h2D413CCD, 32'h8000};
    vecs[2] = '{32'hE0000000, 32'h00000000, 32'h6487ED51, 32'h20000000, 32'h8000};
    vecs[3] = '{32'hE0000000, 32'hE0000000, 32'hB49A0E04, 32'h2D413CCD, 32'h8000};
    vecs[4] = '{32'h00000000, 32'hE0000000, 32'hCDBC0957, 32'h20000000, 32'h8000};
    vecs[5] = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 0};

    reset = 1'b1;
    start = 1'b0;
    x_in  = '0;
    y_in  = '0;
    tick();
    tick();
    reset = 1'b0;
    checkOutput("reset angle", angle_out, 32'd0, 0);
    checkOutput("reset mag", mag_out, 32'd0, 0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0, 0);
    checkOutput("reset done", {31'd0, done}, 32'd0, 0);

    for (int n = 0; n < 6; n++) begin
      applyStimulus(vecs[n].x, vecs[n].y);
      if (n == 0) checkOutput("busy after accept", {31'd0, busy}, 32'd1, 0);
      waitDone(lat);
      checkOutput($sformatf("vec%0d latency", n), lat, 32'd17, 0);
      checkOutput($sformatf("vec%0d angle", n), angle_out, vecs[n].expAngle, vecs[n].tol);
      checkOutput($sformatf("vec%0d mag", n), mag_out, vecs[n].expMag, vecs[n].tol);
      if (n == 0) begin
        tick();
        checkOutput("done pulse width", {31'd0, done}, 32'd0, 0);
        checkOutput("busy after done", {31'd0, busy}, 32'd0, 0);
      end
    end

    runModelOp("max diag", 32'h30000000, 32'h30000000);
    runModelOp("max neg diag", 32'hD0000000, 32'hD0000000);
    runModelOp("near +pi", 32'hD0000000, 32'h00000001);
    runModelOp("near -pi", 32'hD0000000, 32'hFFFFFFFF);
    runModelOp("max -x", 32'hD0000000, 32'h00000000);

    for (int n = 0; n < 30; n++) begin
      do begin
        rx = randComp();
        ry = randComp();
      end while (absInt(rx) < 32'h08000000 && absInt(ry) < 32'h08000000);
      runModelOp($sformatf("rand%0d", n), rx, ry);
    end

    // A second start while busy must not disturb the running operation.
    applyStimulus(32'h20000000, 32'h10000000);
    for (int k = 1; k <= 4; k++) tick();
    x_in  = 32'hE0000000;
    y_in  = 32'hE8000000;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    doneCount = 0;
    for (int k = 6; k <= 40; k++) begin
      tick();
      if (done) begin
        doneCount++;
        if (lat < 0) begin
          lat = k;
          checkModel("ignored start", 32'h20000000, 32'h10000000);
        end
      end
    end
    checkOutput("ignored start latency", lat, 32'd17, 0);
    checkOutput("ignored start done count", doneCount, 32'd1, 0);

    // Restart in the done cycle.
    applyStimulus(32'h18000000, 32'hF0000000);
    waitDone(lat);
    checkOutput("b2b first latency", lat, 32'd17, 0);
    applyStimulus(32'hF4000000, 32'h22000000);
    checkOutput("b2b busy", {31'd0, busy}, 32'd1, 0);
    waitDone(lat);
    checkOutput("b2b second latency", lat, 32'd17, 0);
    if (lat > 0) checkModel("b2b second", 32'hF4000000, 32'h22000000);

    // Reset mid-operation clears outputs and suppresses done.
    applyStimulus(32'h10000000, 32'h10000000);
    for (int k = 1; k <= 7; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("mid reset busy", {31'd0, busy}, 32'd0, 0);
    checkOutput("mid reset angle", angle_out, 32'd0, 0);
    checkOutput("mid reset mag", mag_out, 32'd0, 0);
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done) seen++;
    end
    checkOutput("mid reset no done", seen, 32'd0, 0);
    runModelOp("after reset", 32'h1C000000, 32'hE4000000);

    // Reset and start together: reset wins.
    x_in  = 32'h20000000;
    y_in  = 32'h20000000;
    start = 1'b1;
    reset = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b0;
    checkOutput("reset+start busy", {31'd0, busy}, 32'd0, 0);
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done || busy) seen++;
    end
    checkOutput("reset+start idle", seen, 32'd0, 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
